// File: rtl/pcie_dll_tx_seq.sv
// DLL transmit sequencer: checks TLP framing, tags beats with a 12-bit sequence number and
// buffers them toward the link. Optional error counter enabled by macro PCIE_DLL_TX_ERR_CNT_EN.
module pcie_dll_tx_seq #(
  parameter int DATA_WIDTH       = 256,
  parameter int TLP_HEADER_WIDTH = 128,
  parameter int FIFO_DEPTH       = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        tx_valid,
  input  logic [TLP_HEADER_WIDTH-1:0] tx_header,
  input  logic [DATA_WIDTH-1:0]       tx_data,
  input  logic                        tx_sop,
  input  logic                        tx_eop,
  output logic                        tx_ready,
  output logic                        dl_valid,
  output logic [TLP_HEADER_WIDTH-1:0] dl_header,
  output logic [DATA_WIDTH-1:0]       dl_data,
  output logic                        dl_sop,
  output logic                        dl_eop,
  output logic [11:0]                 dl_seq,
  input  logic                        dl_ready,
  output logic                        proto_err
`ifdef PCIE_DLL_TX_ERR_CNT_EN
  ,
  output logic [7:0]                  err_cnt
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [PTR_W-1:0] PTR_ONE = {{(PTR_W-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } state_t;

  state_t                      state_r;
  state_t                      state_nxt_s;
  logic [11:0]                 next_seq_r;
  logic [11:0]                 cur_seq_r;
  logic [11:0]                 tag_seq_s;
  logic                        proto_err_r;

  logic [TLP_HEADER_WIDTH-1:0] hdr_mem_r  [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]       data_mem_r [FIFO_DEPTH];
  logic                        sop_mem_r  [FIFO_DEPTH];
  logic                        eop_mem_r  [FIFO_DEPTH];
  logic [11:0]                 seq_mem_r  [FIFO_DEPTH];
  logic [PTR_W-1:0]            wr_ptr_r;
  logic [PTR_W-1:0]            rd_ptr_r;
  logic [CNT_W-1:0]            mem_cnt_r;
  logic [CNT_W-1:0]            mem_cnt_nxt_s;
  logic [CNT_W-1:0]            occ_nxt_s;

  logic                        tx_ready_r;
  logic                        dl_valid_r;
  logic [TLP_HEADER_WIDTH-1:0] dl_header_r;
  logic [DATA_WIDTH-1:0]       dl_data_r;
  logic                        dl_sop_r;
  logic                        dl_eop_r;
  logic [11:0]                 dl_seq_r;

  logic accept_s;
  logic pop_s;
  logic out_free_s;
  logic keep_s;
  logic err_s;
  logic mem_empty_s;
  logic mem_rd_s;
  logic mem_wr_s;
  logic bypass_s;
  logic out_valid_nxt_s;

  // The dl_* registers act as the queue head; the memory holds the beats queued behind it,
  // so total occupancy is mem_cnt_r plus dl_valid_r.
  always_comb begin
    accept_s    = tx_valid & tx_ready_r;
    pop_s       = dl_valid_r & dl_ready;
    out_free_s  = ~dl_valid_r | pop_s;
    keep_s      = 1'b0;
    err_s       = 1'b0;
    tag_seq_s   = cur_seq_r;
    state_nxt_s = state_r;
    if (accept_s) begin
      case (state_r)
        IDLE: begin
          if (tx_sop) begin
            keep_s      = 1'b1;
            tag_seq_s   = next_seq_r;
            state_nxt_s = tx_eop ? IDLE : IN_PKT;
          end else begin
            err_s = 1'b1;
          end
        end
        IN_PKT: begin
          keep_s      = 1'b1;
          state_nxt_s = tx_eop ? IDLE : IN_PKT;
          if (tx_sop) begin
            err_s     = 1'b1;
            tag_seq_s = next_seq_r;
          end else begin
            tag_seq_s = cur_seq_r;
          end
        end
        default: begin
          keep_s      = 1'b0;
          err_s       = 1'b0;
          state_nxt_s = IDLE;
        end
      endcase
    end else begin
      keep_s = 1'b0;
    end

    mem_empty_s     = (mem_cnt_r == {CNT_W{1'b0}});
    mem_rd_s        = out_free_s & ~mem_empty_s;
    bypass_s        = out_free_s & mem_empty_s & keep_s;
    mem_wr_s        = keep_s & ~bypass_s;
    out_valid_nxt_s = out_free_s ? (mem_rd_s | bypass_s) : 1'b1;

    if (mem_wr_s && !mem_rd_s) begin
      mem_cnt_nxt_s = mem_cnt_r + CNT_ONE;
    end else if (!mem_wr_s && mem_rd_s) begin
      mem_cnt_nxt_s = mem_cnt_r - CNT_ONE;
    end else begin
      mem_cnt_nxt_s = mem_cnt_r;
    end
    occ_nxt_s = mem_cnt_nxt_s + {{(CNT_W-1){1'b0}}, out_valid_nxt_s};
  end

  // Input framing FSM, sequence numbering and protocol error pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      next_seq_r  <= 12'd0;
      cur_seq_r   <= 12'd0;
      proto_err_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      proto_err_r <= err_s;
      if (keep_s && tx_sop) begin
        next_seq_r <= next_seq_r + 12'd1;
        cur_seq_r  <= next_seq_r;
      end
    end
  end

  // Beat storage; contents are only meaningful between the pointers
  always_ff @(posedge clk) begin
    if (mem_wr_s) begin
      hdr_mem_r[wr_ptr_r]  <= tx_header;
      data_mem_r[wr_ptr_r] <= tx_data;
      sop_mem_r[wr_ptr_r]  <= tx_sop;
      eop_mem_r[wr_ptr_r]  <= tx_eop;
      seq_mem_r[wr_ptr_r]  <= tag_seq_s;
    end
  end

  // Queue pointers, registered ready and the output head register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r    <= {PTR_W{1'b0}};
      rd_ptr_r    <= {PTR_W{1'b0}};
      mem_cnt_r   <= {CNT_W{1'b0}};
      tx_ready_r  <= 1'b0;
      dl_valid_r  <= 1'b0;
      dl_header_r <= {TLP_HEADER_WIDTH{1'b0}};
      dl_data_r   <= {DATA_WIDTH{1'b0}};
      dl_sop_r    <= 1'b0;
      dl_eop_r    <= 1'b0;
      dl_seq_r    <= 12'd0;
    end else begin
      mem_cnt_r  <= mem_cnt_nxt_s;
      tx_ready_r <= (occ_nxt_s < DEPTH_C);
      dl_valid_r <= out_valid_nxt_s;
      if (mem_wr_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (mem_rd_s) begin
        rd_ptr_r    <= rd_ptr_r + PTR_ONE;
        dl_header_r <= hdr_mem_r[rd_ptr_r];
        dl_data_r   <= data_mem_r[rd_ptr_r];
        dl_sop_r    <= sop_mem_r[rd_ptr_r];
        dl_eop_r    <= eop_mem_r[rd_ptr_r];
        dl_seq_r    <= seq_mem_r[rd_ptr_r];
      end else if (bypass_s) begin
        dl_header_r <= tx_header;
        dl_data_r   <= tx_data;
        dl_sop_r    <= tx_sop;
        dl_eop_r    <= tx_eop;
        dl_seq_r    <= tag_seq_s;
      end
    end
  end

`ifdef PCIE_DLL_TX_ERR_CNT_EN
  logic [7:0] err_cnt_r;

  // Saturating count of framing errors, stepped alongside each proto_err pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt_r <= 8'd0;
    end else if (err_s && (err_cnt_r != 8'd255)) begin
      err_cnt_r <= err_cnt_r + 8'd1;
    end
  end

  assign err_cnt = err_cnt_r;
`endif

  assign tx_ready  = tx_ready_r;
  assign dl_valid  = dl_valid_r;
  assign dl_header = dl_header_r;
  assign dl_data   = dl_data_r;
  assign dl_sop    = dl_sop_r;
  assign dl_eop    = dl_eop_r;
  assign dl_seq    = dl_seq_r;
  assign proto_err = proto_err_r;

endmodule

// File: tb/tb_pcie_dll_tx_seq.sv
// Self-checking bench for pcie_dll_tx_seq: directed scenarios plus random traffic, checked
// against a queue-based model of the transmit path.
module tb_pcie_dll_tx_seq;

  localparam int DW    = 256;
  localparam int HW    = 128;
  localparam int DEPTH = 4;

  logic          clk;
  logic          rst_n;
  logic          tx_valid;
  logic [HW-1:0] tx_header;
  logic [DW-1:0] tx_data;
  logic          tx_sop;
  logic          tx_eop;
  logic          tx_ready;
  logic          dl_valid;
  logic [HW-1:0] dl_header;
  logic [DW-1:0] dl_data;
  logic          dl_sop;
  logic          dl_eop;
  logic [11:0]   dl_seq;
  logic          dl_ready;
  logic          proto_err;
`ifdef PCIE_DLL_TX_ERR_CNT_EN
  logic [7:0]    err_cnt;
`endif

  pcie_dll_tx_seq #(
    .DATA_WIDTH(DW),
    .TLP_HEADER_WIDTH(HW),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .tx_valid(tx_valid),
    .tx_header(tx_header),
    .tx_data(tx_data),
    .tx_sop(tx_sop),
    .tx_eop(tx_eop),
    .tx_ready(tx_ready),
    .dl_valid(dl_valid),
    .dl_header(dl_header),
    .dl_data(dl_data),
    .dl_sop(dl_sop),
    .dl_eop(dl_eop),
    .dl_seq(dl_seq),
    .dl_ready(dl_ready),
    .proto_err(proto_err)
`ifdef PCIE_DLL_TX_ERR_CNT_EN
    ,
    .err_cnt(err_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [HW-1:0] h;
    logic [DW-1:0] d;
    logic          sop;
    logic          eop;
    logic [11:0]   seq;
  } beat_t;

  // Reference model: everything accepted and not yet popped, oldest first
  beat_t       q[$];
  logic        m_ready;
  logic        m_err;
  logic        m_zero;
  logic        m_in_pkt;
  logic [11:0] m_next;
  logic [11:0] m_cur;
  int          m_cnt;
  int          total = 0;
  int          bad   = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_next   = 12'd0;
    m_cur    = 12'd0;
    m_in_pkt = 1'b0;
    m_ready  = 1'b0;
    m_err    = 1'b0;
    m_zero   = 1'b1;
    m_cnt    = 0;
  endtask

  // Apply the framing rules to the inputs presented for the coming rising edge
  task automatic model_edge();
    beat_t b;
    logic  acc;
    if (!rst_n) begin
      model_reset();
    end else begin
      m_zero = 1'b0;
      m_err  = 1'b0;
      acc    = tx_valid && m_ready;
      if (q.size() != 0 && dl_ready) b = q.pop_front();
      if (acc) begin
        b.h   = tx_header;
        b.d   = tx_data;
        b.sop = tx_sop;
        b.eop = tx_eop;
        if (tx_sop) begin
          m_err    = m_in_pkt;
          m_cur    = m_next;
          m_next   = m_next + 12'd1;
          m_in_pkt = !tx_eop;
          b.seq    = m_cur;
          q.push_back(b);
        end else if (m_in_pkt) begin
          b.seq    = m_cur;
          m_in_pkt = !tx_eop;
          q.push_back(b);
        end else begin
          m_err = 1'b1;
        end
      end
      if (m_err && m_cnt < 255) m_cnt++;
      m_ready = (q.size() < DEPTH);
    end
  endtask

  task automatic check();
    chk("tx_ready", {{(DW-1){1'b0}}, tx_ready}, {{(DW-1){1'b0}}, m_ready});
    chk("dl_valid", {{(DW-1){1'b0}}, dl_valid}, {{(DW-1){1'b0}}, (q.size() != 0)});
    chk("proto_err", {{(DW-1){1'b0}}, proto_err}, {{(DW-1){1'b0}}, m_err});
`ifdef PCIE_DLL_TX_ERR_CNT_EN
    chk("err_cnt", {{(DW-8){1'b0}}, err_cnt}, DW'(m_cnt));
`endif
    if (q.size() != 0) begin
      chk("dl_data", dl_data, q[0].d);
      chk("dl_header", {{(DW-HW){1'b0}}, dl_header}, {{(DW-HW){1'b0}}, q[0].h});
      chk("dl_sop", {{(DW-1){1'b0}}, dl_sop}, {{(DW-1){1'b0}}, q[0].sop});
      chk("dl_eop", {{(DW-1){1'b0}}, dl_eop}, {{(DW-1){1'b0}}, q[0].eop});
      chk("dl_seq", {{(DW-12){1'b0}}, dl_seq}, {{(DW-12){1'b0}}, q[0].seq});
    end else if (m_zero) begin
      chk("rst_data", dl_data, {DW{1'b0}});
      chk("rst_header", {{(DW-HW){1'b0}}, dl_header}, {DW{1'b0}});
      chk("rst_flags", {{(DW-14){1'b0}}, dl_sop, dl_eop, dl_seq}, {DW{1'b0}});
    end
  endtask

  function automatic logic [DW-1:0] rnd_data();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic cyc(input logic r, input logic v, input logic s, input logic e,
                     input logic [DW-1:0] d, input logic dr);
    @(negedge clk);
    check();
    rst_n     = r;
    tx_valid  = v;
    tx_sop    = s;
    tx_eop    = e;
    tx_data   = d;
    tx_header = {$urandom, $urandom, $urandom, $urandom};
    dl_ready  = dr;
    model_edge();
  endtask

  task automatic beat(input logic v, input logic s, input logic e, input logic dr);
    cyc(1'b1, v, s, e, rnd_data(), dr);
  endtask

  task automatic do_reset();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, {DW{1'b0}}, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, {DW{1'b0}}, 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) beat(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    rst_n     = 1'b0;
    tx_valid  = 1'b0;
    tx_sop    = 1'b0;
    tx_eop    = 1'b0;
    tx_data   = {DW{1'b0}};
    tx_header = {HW{1'b0}};
    dl_ready  = 1'b0;
    repeat (2) @(posedge clk);
    model_reset();

    // Reset state, then a single-beat TLP with a fixed payload
    cyc(1'b1, 1'b0, 1'b0, 1'b0, {DW{1'b0}}, 1'b1);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 256'hA5, 1'b1);
    idle(3);

    // Three-beat TLP followed by a two-beat TLP
    do_reset();
    beat(1'b1, 1'b1, 1'b0, 1'b1);
    beat(1'b1, 1'b0, 1'b0, 1'b1);
    beat(1'b1, 1'b0, 1'b1, 1'b1);
    beat(1'b1, 1'b1, 1'b0, 1'b1);
    beat(1'b1, 1'b0, 1'b1, 1'b1);
    idle(3);

    // Back-pressure: five beats offered with the link stalled, then released
    do_reset();
    beat(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) beat(1'b1, 1'b0, 1'b0, 1'b0);
    beat(1'b1, 1'b0, 1'b1, 1'b0);
    beat(1'b1, 1'b0, 1'b1, 1'b0);
    beat(1'b1, 1'b0, 1'b1, 1'b1);
    beat(1'b1, 1'b0, 1'b1, 1'b1);
    idle(6);

    // Framing errors: stray non-sop beat, then an sop arriving mid-packet
    do_reset();
    beat(1'b1, 1'b0, 1'b1, 1'b1);
    beat(1'b0, 1'b0, 1'b0, 1'b1);
    beat(1'b1, 1'b1, 1'b0, 1'b1);
    beat(1'b1, 1'b0, 1'b0, 1'b1);
    beat(1'b1, 1'b1, 1'b0, 1'b1);
    beat(1'b1, 1'b0, 1'b1, 1'b1);
    idle(3);
`ifdef PCIE_DLL_TX_ERR_CNT_EN
    chk("err_cnt_two", {{(DW-8){1'b0}}, err_cnt}, 256'd2);
`endif

    // Sequence number wrap over 4097 single-beat TLPs
    do_reset();
    for (int i = 0; i < 4097; i++) beat(1'b1, 1'b1, 1'b1, 1'b1);
    idle(3);

    // Reset in the middle of a TLP with two beats buffered
    do_reset();
    beat(1'b1, 1'b1, 1'b0, 1'b0);
    beat(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, rnd_data(), 1'b0);
    beat(1'b1, 1'b1, 1'b1, 1'b1);
    beat(1'b1, 1'b1, 1'b1, 1'b1);
    idle(3);

    // Random traffic with random back-pressure and occasional reset
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        cyc(1'b0, 1'b0, 1'b0, 1'b0, rnd_data(), 1'b1);
      end else begin
        beat(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
             ($urandom_range(0, 1) == 1), ($urandom_range(0, 3) != 0));
      end
    end
    idle(8);
    @(negedge clk);
    check();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
